// File: rtl/hazard_pkg.sv
// Purpose: shared types for the EX-stage hazard controller (stage tag records, FSM state).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Register-index width baked into the tag records; the top-level REG_W must match.
    localparam int HZ_REG_W = 4;

    // Link register; the decoder already steers call destinations here, so no special case is needed.
    localparam logic [HZ_REG_W-1:0] REG_R15 = HZ_REG_W'(15);

    // Destination-side tag carried by every stage (EX, MA, RW).
    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rd;
        logic                writes_rd;
        logic                is_load;
    } stage_rec_t;

    // EX additionally remembers what it reads, for forwarding lookups.
    typedef struct packed {
        stage_rec_t          tag;
        logic [HZ_REG_W-1:0] src1;
        logic [HZ_REG_W-1:0] src2;
        logic                uses1;
        logic                uses2;
    } ex_rec_t;

    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/tag_match.sv
// Purpose: compares one downstream stage tag against one EX source operand.
// Latency: combinational.
// Backpressure: none.
// Ports: stage (MA or RW tag), ex_valid/ex_uses/ex_src (EX operand), hit (forwarding candidate).
module tag_match
    import hazard_pkg::*;
(
    input  stage_rec_t          stage,
    input  logic                ex_valid,
    input  logic                ex_uses,
    input  logic [HZ_REG_W-1:0] ex_src,
    output logic                hit
);

    // Load-ness is judged by the caller; a hit is purely "same register, both live".
    logic unused_is_load;
    assign unused_is_load = stage.is_load;

    assign hit = stage.valid && stage.writes_rd && ex_valid && ex_uses && (stage.rd == ex_src);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Purpose: EX-stage interlock/forwarding controller: forwarding selects, load-use stall, branch flush, event counters.
// Latency: forwarding selects combinational from registered tags; stall/flush/bubble combinational, act at next edge.
// Backpressure: load-use holds IF/OF for one cycle and bubbles EX; taken branch flushes OF and bubbles EX.
// Ports: clk/reset (sync, active high); OF_* describe the instruction in OF; EX_is_Branch_Taken from branch unit;
//        is_MA/RW_EX_conflict_src1/2 drive operand muxes; stall_IF_OF/flush_OF/bubble_EX to front end;
//        stall_count/flush_count saturating event counters.
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = HZ_REG_W,
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             OF_valid,
    input  logic [REG_W-1:0] OF_src1,
    input  logic [REG_W-1:0] OF_src2,
    input  logic             OF_uses_src1,
    input  logic             OF_uses_src2,
    input  logic [REG_W-1:0] OF_rd,
    input  logic             OF_writes_rd,
    input  logic             OF_is_load,
    input  logic             EX_is_Branch_Taken,
    output logic             is_MA_EX_conflict_src1,
    output logic             is_MA_EX_conflict_src2,
    output logic             is_RW_EX_conflict_src1,
    output logic             is_RW_EX_conflict_src2,
    output logic             stall_IF_OF,
    output logic             flush_OF,
    output logic             bubble_EX,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ex_rec_t    ex_r;
    stage_rec_t ma_r;
    stage_rec_t rw_r;
    hz_state_t  state;
    ex_rec_t    of_rec;

    logic hit_ma1, hit_ma2, hit_rw1, hit_rw2;
    logic load_use;

    // RW only feeds the register file from here on; its load flag is never consulted.
    logic unused_rw_load;
    assign unused_rw_load = rw_r.is_load;

    always_comb begin
        of_rec               = '0;
        of_rec.tag.valid     = OF_valid;
        of_rec.tag.rd        = OF_rd;
        of_rec.tag.writes_rd = OF_writes_rd;
        of_rec.tag.is_load   = OF_is_load;
        of_rec.src1          = OF_src1;
        of_rec.src2          = OF_src2;
        of_rec.uses1         = OF_uses_src1;
        of_rec.uses2         = OF_uses_src2;
    end

    tag_match u_ma_src1 (.stage(ma_r), .ex_valid(ex_r.tag.valid), .ex_uses(ex_r.uses1), .ex_src(ex_r.src1), .hit(hit_ma1));
    tag_match u_ma_src2 (.stage(ma_r), .ex_valid(ex_r.tag.valid), .ex_uses(ex_r.uses2), .ex_src(ex_r.src2), .hit(hit_ma2));
    tag_match u_rw_src1 (.stage(rw_r), .ex_valid(ex_r.tag.valid), .ex_uses(ex_r.uses1), .ex_src(ex_r.src1), .hit(hit_rw1));
    tag_match u_rw_src2 (.stage(rw_r), .ex_valid(ex_r.tag.valid), .ex_uses(ex_r.uses2), .ex_src(ex_r.src2), .hit(hit_rw2));

    // A load sitting in MA has no data yet, so it blocks MA forwarding. It still counts as
    // the youngest writer, which suppresses the stale RW value.
    assign is_MA_EX_conflict_src1 = hit_ma1 && !ma_r.is_load;
    assign is_MA_EX_conflict_src2 = hit_ma2 && !ma_r.is_load;
    assign is_RW_EX_conflict_src1 = hit_rw1 && !hit_ma1;
    assign is_RW_EX_conflict_src2 = hit_rw2 && !hit_ma2;

    assign load_use = ex_r.tag.valid && ex_r.tag.is_load && ex_r.tag.writes_rd && OF_valid &&
                      ((OF_uses_src1 && (OF_src1 == ex_r.tag.rd)) ||
                       (OF_uses_src2 && (OF_src2 == ex_r.tag.rd)));

    // The taken branch squashes the OF instruction, so its load-use stall is moot.
    assign stall_IF_OF = load_use && !EX_is_Branch_Taken;
    assign flush_OF    = EX_is_Branch_Taken;
    assign bubble_EX   = load_use || EX_is_Branch_Taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r <= '0;
            ma_r <= '0;
            rw_r <= '0;
        end else begin
            rw_r <= ma_r;
            ma_r <= ex_r.tag;
            if (OF_valid && !bubble_EX) begin
                ex_r <= of_rec;
            end else begin
                ex_r <= '0;
            end
        end
    end

    // One stall cycle is always enough: the load reaches MA, the consumer then follows it
    // one stage behind and picks the data up from RW.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (stall_IF_OF) state <= LD_STALL;
                LD_STALL: state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_IF_OF && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_OF && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    // EX is always a bubble while in LD_STALL, so a fresh load-use here means the pipeline lost sync.
    a_no_back_to_back_ld_stall: assert property (@(posedge clk) disable iff (reset)
        (state == LD_STALL) |-> !load_use);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       OF_valid;
    logic [3:0] OF_src1, OF_src2, OF_rd;
    logic       OF_uses_src1, OF_uses_src2, OF_writes_rd, OF_is_load;
    logic       EX_is_Branch_Taken;

    logic        ma1, ma2, rw1, rw2, stall, flush, bubble;
    logic [15:0] stall_count, flush_count;
    logic        s_ma1, s_ma2, s_rw1, s_rw2, s_stall, s_flush, s_bubble;
    logic [3:0]  s_stall_count, s_flush_count;

    always #5 clk = ~clk;

    ex_hazard_ctrl dut (
        .clk(clk), .reset(reset), .OF_valid(OF_valid), .OF_src1(OF_src1), .OF_src2(OF_src2),
        .OF_uses_src1(OF_uses_src1), .OF_uses_src2(OF_uses_src2), .OF_rd(OF_rd),
        .OF_writes_rd(OF_writes_rd), .OF_is_load(OF_is_load), .EX_is_Branch_Taken(EX_is_Branch_Taken),
        .is_MA_EX_conflict_src1(ma1), .is_MA_EX_conflict_src2(ma2),
        .is_RW_EX_conflict_src1(rw1), .is_RW_EX_conflict_src2(rw2),
        .stall_IF_OF(stall), .flush_OF(flush), .bubble_EX(bubble),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    ex_hazard_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .OF_valid(OF_valid), .OF_src1(OF_src1), .OF_src2(OF_src2),
        .OF_uses_src1(OF_uses_src1), .OF_uses_src2(OF_uses_src2), .OF_rd(OF_rd),
        .OF_writes_rd(OF_writes_rd), .OF_is_load(OF_is_load), .EX_is_Branch_Taken(EX_is_Branch_Taken),
        .is_MA_EX_conflict_src1(s_ma1), .is_MA_EX_conflict_src2(s_ma2),
        .is_RW_EX_conflict_src1(s_rw1), .is_RW_EX_conflict_src2(s_rw2),
        .stall_IF_OF(s_stall), .flush_OF(s_flush), .bubble_EX(s_bubble),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    typedef struct {
        bit v; int rd; bit wr; bit ld; int s1; bit u1; int s2; bit u2;
    } instr_t;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    // Model: in-flight instructions by age (0 = EX, 1 = MA, 2 = RW) and raw event counts.
    instr_t pipe[3];
    instr_t of_i;
    bit     cur_br;
    int     m_stalls = 0;
    int     m_flushes = 0;

    function automatic instr_t nop();
        instr_t i;
        i = '{v:0, rd:0, wr:0, ld:0, s1:0, u1:0, s2:0, u2:0};
        return i;
    endfunction

    function automatic instr_t alu(int rd, int a, int b);
        instr_t i;
        i = '{v:1, rd:rd, wr:1, ld:0, s1:a, u1:1, s2:b, u2:1};
        return i;
    endfunction

    function automatic instr_t ldi(int rd, int base);
        instr_t i;
        i = '{v:1, rd:rd, wr:1, ld:1, s1:base, u1:1, s2:0, u2:0};
        return i;
    endfunction

    // Where operand n of the EX instruction gets its value: 0 = register file, 1 = MA, 2 = RW.
    // The youngest older writer decides; a load still in MA cannot supply data.
    function automatic int fwd_from(int n);
        int  src;
        bit  uses;
        if (!pipe[0].v) return 0;
        src  = (n == 1) ? pipe[0].s1 : pipe[0].s2;
        uses = (n == 1) ? pipe[0].u1 : pipe[0].u2;
        if (!uses) return 0;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].wr && pipe[k].rd == src) begin
                if (k == 1 && pipe[1].ld) return 0;
                return k;
            end
        end
        return 0;
    endfunction

    function automatic bit m_load_use();
        instr_t e;
        e = pipe[0];
        if (!(e.v && e.ld && e.wr && of_i.v)) return 0;
        return (of_i.u1 && of_i.s1 == e.rd) || (of_i.u2 && of_i.s2 == e.rd);
    endfunction

    function automatic int sat(int n, int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) pipe[k] <= nop();
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            if (of_i.v && !m_load_use() && !cur_br) pipe[0] <= of_i;
            else                                    pipe[0] <= nop();
            if (m_load_use() && !cur_br) m_stalls <= m_stalls + 1;
            if (cur_br)                  m_flushes <= m_flushes + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int  f1, f2;
            bit  lu;
            f1 = fwd_from(1);
            f2 = fwd_from(2);
            lu = m_load_use();
            chk("ma_src1", ma1, int'(f1 == 1));
            chk("ma_src2", ma2, int'(f2 == 1));
            chk("rw_src1", rw1, int'(f1 == 2));
            chk("rw_src2", rw2, int'(f2 == 2));
            chk("stall", stall, int'(lu && !cur_br));
            chk("flush", flush, int'(cur_br));
            chk("bubble", bubble, int'(lu || cur_br));
            chk("stall_count", stall_count, sat(m_stalls, 16));
            chk("flush_count", flush_count, sat(m_flushes, 16));
            chk("small_fwd", {s_ma1, s_ma2, s_rw1, s_rw2}, {ma1, ma2, rw1, rw2});
            chk("small_ctl", {s_stall, s_flush, s_bubble}, int'({lu && !cur_br, cur_br, lu || cur_br}));
            chk("small_stall_count", s_stall_count, sat(m_stalls, 4));
            chk("small_flush_count", s_flush_count, sat(m_flushes, 4));
        end
    end

    task automatic drive(input instr_t i, input bit br);
        @(posedge clk);
        #1;
        of_i               = i;
        cur_br             = br;
        OF_valid           = i.v;
        OF_rd              = i.rd[3:0];
        OF_writes_rd       = i.wr;
        OF_is_load         = i.ld;
        OF_src1            = i.s1[3:0];
        OF_uses_src1       = i.u1;
        OF_src2            = i.s2[3:0];
        OF_uses_src2       = i.u2;
        EX_is_Branch_Taken = br;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) drive(nop(), 0);
    endtask

    initial begin
        reset = 1'b1;
        of_i  = nop();
        cur_br = 0;
        OF_valid = 0; OF_rd = 0; OF_writes_rd = 0; OF_is_load = 0;
        OF_src1 = 0; OF_uses_src1 = 0; OF_src2 = 0; OF_uses_src2 = 0;
        EX_is_Branch_Taken = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1;

        // Reset state.
        @(negedge clk);
        chk("reset_outputs", {ma1, ma2, rw1, rw2, stall, flush, bubble}, 0);
        chk("reset_counters", stall_count + flush_count, 0);

        // ADD r1 ; ADD r2,r1,r3 : MA forward on operand A only.
        drive(alu(1, 5, 6), 0);
        drive(alu(2, 1, 3), 0);
        drive(nop(), 0);
        @(negedge clk);
        chk("t1_fwd", {ma1, ma2, rw1, rw2}, 4'b1000);
        chk("t1_stall", stall, 0);
        drain();

        // ADD r1 ; NOP ; SUB r4,r5,r1 : RW forward on operand B for one cycle.
        drive(alu(1, 5, 6), 0);
        drive(nop(), 0);
        drive(alu(4, 5, 1), 0);
        drive(nop(), 0);
        @(negedge clk);
        chk("t2_fwd", {ma1, ma2, rw1, rw2}, 4'b0001);
        drive(nop(), 0);
        @(negedge clk);
        chk("t2_fwd_gone", rw2, 0);
        drain();

        // LD r1 ; ADD r2,r1,r1 : one stall, then RW forward on both operands.
        drive(ldi(1, 7), 0);
        drive(alu(2, 1, 1), 0);
        @(negedge clk);
        chk("t3_stall", {stall, bubble}, 2'b11);
        drive(alu(2, 1, 1), 0);
        @(negedge clk);
        chk("t3_stall_released", stall, 0);
        drive(nop(), 0);
        @(negedge clk);
        chk("t3_fwd", {ma1, ma2, rw1, rw2}, 4'b0011);
        chk("t3_stall_count", stall_count, 1);
        drain();

        // ADD r1 ; ADD r1 ; ADD r2,r1,r1 : the younger producer in MA wins.
        drive(alu(1, 8, 9), 0);
        drive(alu(1, 8, 9), 0);
        drive(alu(2, 1, 1), 0);
        drive(nop(), 0);
        @(negedge clk);
        chk("t4_fwd", {ma1, ma2, rw1, rw2}, 4'b1100);
        drain();

        // r0 is an ordinary register.
        drive(alu(0, 5, 6), 0);
        drive(alu(7, 0, 0), 0);
        drive(nop(), 0);
        @(negedge clk);
        chk("r0_fwd", {ma1, ma2, rw1, rw2}, 4'b1100);
        drain();

        // Taken branch coinciding with a load-use.
        drive(ldi(3, 8), 0);
        drive(alu(4, 3, 3), 1);
        @(negedge clk);
        chk("t5_ctl", {stall, flush, bubble}, 3'b011);
        drive(nop(), 0);
        @(negedge clk);
        chk("t5_flush_count", flush_count, 1);
        chk("t5_fsm_run", int'(dut.state), 0);
        drain();

        // Reset while in LD_STALL.
        drive(ldi(5, 9), 0);
        drive(alu(6, 5, 0), 0);
        @(negedge clk);
        chk("t6_stall", stall, 1);
        drive(nop(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_in_ld_stall", int'(dut.state), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_outputs", {ma1, ma2, rw1, rw2, stall, flush, bubble}, 0);
        chk("t6_counters", {stall_count, flush_count}, 0);
        chk("t6_fsm", int'(dut.state), 0);

        // Saturation: 18 stalls and 18 flushes against a 4-bit counter copy.
        for (int n = 0; n < 18; n++) begin
            drive(ldi(1, 2), 0);
            drive(alu(3, 1, 4), 0);
            drive(alu(3, 1, 4), 0);
            drive(nop(), 1);
        end
        drive(nop(), 0);
        drive(nop(), 0);
        @(negedge clk);
        chk("sat_stall_wide", stall_count, 18);
        chk("sat_flush_wide", flush_count, 18);
        chk("sat_stall_small", s_stall_count, 15);
        chk("sat_flush_small", s_flush_count, 15);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
